simon_sequencer: RTL and testbench

- Pattern-memory game controller that consumes the 4-bit pseudo-random word produced by the team's LFSR block.
- Each round, it appends one random symbol (rand_in[1:0]) to a stored sequence and plays the whole sequence on 4 one-hot LEDs.
- It then checks the player's button presses against the stored sequence.
- It reports the current level and a win or lose result to the display logic.

---
 rtl/simon_sequencer.sv | 148 ++++++++++++++
 tb/tb_simon_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// simon_sequencer: pattern-memory game controller.
// Each round one random symbol (rand_in[1:0]) is appended to the stored
// sequence. The whole sequence is then played on four one-hot LEDs and the
// player's presses are checked against it.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   rand_in   LFSR word; only [1:0] is used, sampled in ADD
//   start     level-sampled start/restart (IDLE, WIN, LOSE only)
//   btn_valid one-cycle button press strobe (WAIT_IN only)
//   btn_id    pressed button index
//   led       one-hot symbol display (1111 while in WIN)
//   level     current sequence length
//   busy      high while appending or playing back
//   win/lose  game result flags
module simon_sequencer #(
  parameter int MAX_LEN     = 16,
  parameter int SHOW_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 rand_in,
  input  logic                       start,
  input  logic                       btn_valid,
  input  logic [1:0]                 btn_id,
  output logic [3:0]                 led,
  output logic [$clog2(MAX_LEN):0]   level,
  output logic                       busy,
  output logic                       win,
  output logic                       lose
);

  localparam int LW   = $clog2(MAX_LEN) + 1;
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam logic [TW-1:0] SHOW_END = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE
  } st_t;

  st_t st, nxt;

  logic [1:0]    seq [2**IW];
  logic [LW-1:0] len;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;

  logic show_done, gap_done, last, hit;
  logic unused_rand;

  assign unused_rand = ^rand_in[3:2];

  assign show_done = (timer == SHOW_END);
  assign gap_done  = (timer == GAP_END);
  // len >= 1 in every state where last is consulted, so no underflow.
  assign last      = (LW'(idx) == len - LW'(1));
  assign hit       = (btn_id == seq[idx]);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = st;
    case (st)
      IDLE:     if (start) nxt = ADD;
      ADD:      nxt = SHOW_ON;
      SHOW_ON:  if (show_done) nxt = SHOW_OFF;
      SHOW_OFF: if (gap_done) nxt = last ? WAIT_IN : SHOW_ON;
      WAIT_IN: begin
        if (btn_valid) begin
          if (!hit)      nxt = LOSE;
          else if (last) nxt = (len == LEN_MAX) ? WIN : ADD;
        end
      end
      WIN:      if (start) nxt = ADD;
      LOSE:     if (start) nxt = ADD;
      default:  nxt = IDLE;
    endcase
  end

  // Length, playback/entry index and phase timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len   <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      case (st)
        IDLE, WIN, LOSE: begin
          if (start) begin
            len <= '0;
            idx <= '0;
          end
        end
        ADD: begin
          len   <= len + LW'(1);
          idx   <= '0;
          timer <= '0;
        end
        SHOW_ON: begin
          if (show_done) timer <= '0;
          else           timer <= timer + TW'(1);
        end
        SHOW_OFF: begin
          if (gap_done) begin
            timer <= '0;
            idx   <= last ? '0 : idx + IW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_IN: begin
          if (btn_valid && hit) idx <= last ? '0 : idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sequence storage; contents need no reset since len gates every read.
  always_ff @(posedge clk) begin
    if (st == ADD) seq[len[IW-1:0]] <= rand_in[1:0];
  end

  // Outputs decoded from registered state only
  always_comb begin
    led = 4'b0000;
    if (st == SHOW_ON) led = 4'b0001 << seq[idx];
    else if (st == WIN) led = 4'b1111;
  end

  assign level = len;
  assign busy  = (st == ADD) || (st == SHOW_ON) || (st == SHOW_OFF);
  assign win   = (st == WIN);
  assign lose  = (st == LOSE);

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer (MAX_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2).
// A game-level model (sequence queue plus a playback cycle counter) predicts
// every output each cycle; directed literal checks pin the model itself.
module tb_simon_sequencer;

  localparam int MAXL = 3;
  localparam int S    = 4;
  localparam int G    = 2;
  localparam int LW   = $clog2(MAXL) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    rand_in = 4'b0000;
  logic          start = 1'b0;
  logic          btn_valid = 1'b0;
  logic [1:0]    btn_id = 2'b00;
  logic [3:0]    led;
  logic [LW-1:0] level;
  logic          busy, win, lose;

  int checks = 0;
  int errors = 0;

  simon_sequencer #(.MAX_LEN(MAXL), .SHOW_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .start(start),
    .btn_valid(btn_valid), .btn_id(btn_id), .led(led), .level(level),
    .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  localparam int M_IDLE = 0, M_ADD = 1, M_PLAY = 2, M_WAIT = 3, M_WIN = 4, M_LOSE = 5;
  int mode = M_IDLE;
  int mseq[$];
  int p   = 0;   // cycles elapsed in the current playback
  int pos = 0;   // next expected press position

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mode = M_IDLE; mseq.delete(); p = 0; pos = 0;
      end else begin
        case (mode)
          M_IDLE, M_WIN, M_LOSE: if (start) begin mseq.delete(); mode = M_ADD; end
          M_ADD: begin mseq.push_back(int'(rand_in[1:0])); p = 0; mode = M_PLAY; end
          M_PLAY: begin
            p++;
            if (p == mseq.size() * (S + G)) begin mode = M_WAIT; pos = 0; end
          end
          M_WAIT: if (btn_valid) begin
            if (int'(btn_id) != mseq[pos]) mode = M_LOSE;
            else if (pos == mseq.size() - 1) mode = (mseq.size() == MAXL) ? M_WIN : M_ADD;
            else pos++;
          end
          default: mode = M_IDLE;
        endcase
      end
    end
  end

  function automatic logic [3:0] m_led();
    if (mode == M_WIN) return 4'b1111;
    if (mode == M_PLAY && (p % (S + G)) < S) return 4'b0001 << mseq[p / (S + G)];
    return 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("led",   8'(led),   8'(m_led()));
      chk("level", 8'(level), 8'(mseq.size()));
      chk("busy",  8'(busy),  8'(mode == M_ADD || mode == M_PLAY));
      chk("win",   8'(win),   8'(mode == M_WIN));
      chk("lose",  8'(lose),  8'(mode == M_LOSE));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] id);
    btn_id = id; btn_valid = 1'b1;
    tick(1);
    btn_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin tick(1); n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  initial begin
    // 1. reset
    tick(3);
    chk("rst_led", 8'(led), 8'h0);   chk("rst_level", 8'(level), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0); chk("rst_win", 8'(win), 8'h0);
    chk("rst_lose", 8'(lose), 8'h0);
    rst = 1'b1;
    tick(2);

    // 2. first round, symbol 2
    rand_in = 4'b0110;
    pulse_start();                    // now in ADD
    chk("add_busy", 8'(busy), 8'h1); chk("add_level", 8'(level), 8'h0);
    tick(1);
    chk("r1_level", 8'(level), 8'h1); chk("r1_busy", 8'(busy), 8'h1);
    chk("r1_led0", 8'(led), 8'h4);
    tick(3);
    chk("r1_led3", 8'(led), 8'h4);
    tick(1);
    chk("r1_gap0", 8'(led), 8'h0);
    tick(1);
    chk("r1_gap1", 8'(led), 8'h0);    chk("r1_gap_busy", 8'(busy), 8'h1);
    tick(1);
    chk("r1_wait_busy", 8'(busy), 8'h0);

    // 3. correct press while rand_in supplies symbol 1
    rand_in = 4'b1001;
    press(2'd2);                      // now in ADD
    tick(1);
    chk("r2_level", 8'(level), 8'h2); chk("r2_led0", 8'(led), 8'h4);
    tick(2);
    press(2'd0);                      // ignored during playback
    tick(3);                          // 2nd symbol on
    chk("r2_sym1_led", 8'(led), 8'h2);
    wait_ready("r2_play");
    chk("r2_wait_level", 8'(level), 8'h2);

    // 4. press 2 then wrong 3
    press(2'd2);
    chk("r2_mid_lose", 8'(lose), 8'h0);
    press(2'd3);
    chk("lose_flag", 8'(lose), 8'h1); chk("lose_led", 8'(led), 8'h0);
    press(2'd1);
    chk("lose_hold", 8'(lose), 8'h1); chk("lose_level", 8'(level), 8'h2);

    // 5. restart; sequence {0,3,1}; all-ones word gives symbol 3
    rand_in = 4'b0100;
    pulse_start();
    chk("restart_lose", 8'(lose), 8'h0);
    wait_ready("g1");
    chk("g1_level", 8'(level), 8'h1);
    rand_in = 4'b1111;
    press(2'd0);
    wait_ready("g2");
    rand_in = 4'b0101;
    press(2'd0); press(2'd3);
    wait_ready("g3");
    chk("g3_level", 8'(level), 8'h3);
    press(2'd0); press(2'd3);
    chk("g3_not_yet", 8'(win), 8'h0);
    press(2'd1);
    chk("win_flag", 8'(win), 8'h1);   chk("win_led", 8'(led), 8'hf);
    chk("win_level", 8'(level), 8'h3);
    tick(2);
    chk("win_hold", 8'(win), 8'h1);

    // 6. async reset in the middle of a level-2 playback
    rand_in = 4'b0010;
    pulse_start();
    chk("win_clear", 8'(win), 8'h0);
    wait_ready("h1");
    rand_in = 4'b0011;
    press(2'd2);
    tick(2);
    chk("h2_show", 8'(led), 8'h4);    chk("h2_level", 8'(level), 8'h2);
    #2 rst = 1'b0;
    #1;
    chk("ar_led", 8'(led), 8'h0);     chk("ar_level", 8'(level), 8'h0);
    chk("ar_busy", 8'(busy), 8'h0);   chk("ar_win", 8'(win), 8'h0);
    chk("ar_lose", 8'(lose), 8'h0);
    tick(2);
    rst = 1'b1;
    tick(4);
    chk("idle_busy", 8'(busy), 8'h0); chk("idle_level", 8'(level), 8'h0);
    pulse_start();
    chk("resume_busy", 8'(busy), 8'h1);
    tick(1);
    chk("resume_level", 8'(level), 8'h1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
